hms_merge_stage: RTL and testbench

- Streaming E-record merge stage of the hardware merge sorter, E = 2^E_LOG.
- Upstream, two sorted-batch FIFOs feed a key comparator and a 2:1 batch mux. The mux picks the batch whose head key is smaller.
- This block merges each selected batch with the E records it retained from the previous step. It emits the E smallest records, sorted ascending, and retains the E largest.
- The comparator and mux are leaf modules of this block, specified below.

---
 rtl/hms_merge_stage_pkg.sv | 13 +
 rtl/hms_cas.sv | 19 +
 rtl/hms_comparator.sv | 13 +
 rtl/hms_mux2.sv | 13 +
 rtl/hms_merge_stage.sv | 69 ++++++
 tb/tb_hms_merge_stage.sv | 213 +++++++++++++++++++++
 6 files changed

// File: rtl/hms_merge_stage_pkg.sv
// hms_merge_stage_pkg: shared constants and the key-extract helper for the merge sorter stage.
// Provides the default geometry (E_LOG, DATW, KEYW), the derived batch size and width,
// and key_of(), which returns the sort key held in the low KEYW bits of a record.
package hms_merge_stage_pkg;
   localparam int DEF_E_LOG = 2;
   localparam int DEF_DATW  = 64;
   localparam int DEF_KEYW  = 32;
   localparam int DEF_E     = 1 << DEF_E_LOG;
   localparam int DEF_BW    = DEF_DATW << DEF_E_LOG;
   function automatic logic [DEF_KEYW-1:0] key_of(input logic [DEF_DATW-1:0] r);
      return r[DEF_KEYW-1:0];
   endfunction
endpackage

// File: rtl/hms_cas.sv
// hms_cas: compare-and-swap of two records on their key.
// Ports: A, B are the input records. LO receives the record with the smaller key and
// HI the other one. On equal keys nothing is swapped: A goes to LO and B goes to HI.
module hms_cas
   import hms_merge_stage_pkg::*;
#(
   parameter int DATW = DEF_DATW,
   parameter int KEYW = DEF_KEYW
) (
   input  logic [DATW-1:0] A,
   input  logic [DATW-1:0] B,
   output logic [DATW-1:0] LO,
   output logic [DATW-1:0] HI
);
   logic swap;
   assign swap = B[KEYW-1:0] < A[KEYW-1:0];
   assign LO   = swap ? B : A;
   assign HI   = swap ? A : B;
endmodule

// File: rtl/hms_comparator.sv
// hms_comparator: strict unsigned key compare used to choose which FIFO batch is sent next.
// Ports: A and B are the keys. RSLT = (A < B). On a tie RSLT is 0, which selects the B source.
module hms_comparator
   import hms_merge_stage_pkg::*;
#(
   parameter int KEYW = DEF_KEYW
) (
   input  logic [KEYW-1:0] A,
   input  logic [KEYW-1:0] B,
   output logic            RSLT
);
   assign RSLT = A < B;
endmodule

// File: rtl/hms_mux2.sv
// hms_mux2: combinational 2:1 batch mux.
// Ports: SEL picks the source, IN0 and IN1 are the candidate batches,
// and DOT = SEL ? IN0 : IN1.
module hms_mux2 #(
   parameter int W = 256
) (
   input  logic         SEL,
   input  logic [W-1:0] IN0,
   input  logic [W-1:0] IN1,
   output logic [W-1:0] DOT
);
   assign DOT = SEL ? IN0 : IN1;
endmodule

// File: rtl/hms_merge_stage.sv
// hms_merge_stage: merges each incoming sorted batch with the E records retained from the previous step.
// Ports:
//   CLK, RST : clock and synchronous active-high reset.
//   STALL    : while high, all state and outputs are frozen.
//   DIN      : ascending input batch. DINEN marks it valid.
//   DOT      : the E smallest records, ascending. DOTEN marks it valid, one cycle after acceptance.
module hms_merge_stage
   import hms_merge_stage_pkg::*;
#(
   parameter int E_LOG = DEF_E_LOG,
   parameter int DATW  = DEF_DATW,
   parameter int KEYW  = DEF_KEYW
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       STALL,
   input  logic [(DATW<<E_LOG)-1:0]   DIN,
   input  logic                       DINEN,
   output logic [(DATW<<E_LOG)-1:0]   DOT,
   output logic                       DOTEN
);
   localparam int E  = 1 << E_LOG;
   localparam int BW = DATW << E_LOG;
   localparam int L  = E_LOG + 1;
   logic [BW-1:0]   fb, fb_rev;
   logic [2*BW-1:0] merged;
   logic            primed;
   // Appending the retained records in descending order after the ascending
   // input makes the 2E sequence bitonic, so half-cleaners alone can sort it.
   for (genvar i = 0; i < E; i++) begin : rev
      assign fb_rev[DATW*i +: DATW] = fb[DATW*(E-1-i) +: DATW];
   end
   // Level l compares records that are E>>l apart inside blocks of 2*(E>>l) records.
   for (genvar l = 0; l < L; l++) begin : lvl
      localparam int SH = E_LOG - l;
      localparam int D  = 1 << SH;
      logic [2*BW-1:0] src, dst;
      if (l == 0) begin : first
         assign src = {fb_rev, DIN};
      end else begin : chain
         assign src = lvl[l-1].dst;
      end
      for (genvar p = 0; p < E; p++) begin : cs
         localparam int J = ((p >> SH) << (SH + 1)) | (p & (D - 1));
         hms_cas #(.DATW(DATW), .KEYW(KEYW)) u_cas (
            .A (src[DATW*J +: DATW]),
            .B (src[DATW*(J+D) +: DATW]),
            .LO(dst[DATW*J +: DATW]),
            .HI(dst[DATW*(J+D) +: DATW])
         );
      end
   end
   assign merged = lvl[L-1].dst;
   always_ff @(posedge CLK) begin
      if (RST) begin
         DOT    <= '0;
         DOTEN  <= 1'b0;
         fb     <= '0;
         primed <= 1'b0;
      end else if (!STALL) begin
         DOTEN <= DINEN && primed;
         if (DINEN) begin
            fb     <= primed ? merged[2*BW-1:BW] : DIN;
            primed <= 1'b1;
            if (primed) DOT <= merged[BW-1:0];
         end
      end
   end
endmodule

// File: tb/tb_hms_merge_stage.sv
// tb_hms_merge_stage: self-checking bench for the merge stage and its comparator/mux leaves.
module tb_hms_merge_stage;
   import hms_merge_stage_pkg::*;
   localparam int E    = DEF_E;
   localparam int DATW = DEF_DATW;
   localparam int BW   = DEF_BW;
   typedef logic [BW-1:0]   batch_t;
   typedef logic [DATW-1:0] rec_t;
   typedef struct {
      logic   stall;
      logic   dinen;
      batch_t din;
      logic   exp_en;
      batch_t exp_dot;
   } vec_t;

   logic   CLK = 1'b0, RST = 1'b1, STALL = 1'b0, DINEN = 1'b0;
   batch_t DIN = '0, DOT;
   logic   DOTEN;
   logic [DEF_KEYW-1:0] cmp_a = '0, cmp_b = '0;
   logic   cmp_rslt, mux_sel = 1'b0;
   batch_t mux_in0 = '0, mux_in1 = '0, mux_out;
   int checks = 0, errors = 0;

   rec_t   mfb [E];
   logic   mprimed, men;
   batch_t mdot;

   always #5 CLK = ~CLK;

   hms_merge_stage dut (.CLK(CLK), .RST(RST), .STALL(STALL), .DIN(DIN), .DINEN(DINEN), .DOT(DOT), .DOTEN(DOTEN));
   hms_comparator u_cmp (.A(cmp_a), .B(cmp_b), .RSLT(cmp_rslt));
   hms_mux2 #(.W(BW)) u_mux (.SEL(mux_sel), .IN0(mux_in0), .IN1(mux_in1), .DOT(mux_out));

   function automatic rec_t rec(input logic [31:0] k, input logic [31:0] p);
      return {p, k};
   endfunction

   function automatic batch_t mk(input int unsigned k0, k1, k2, k3, input logic [31:0] p);
      return {rec(k3, p), rec(k2, p), rec(k1, p), rec(k0, p)};
   endfunction

   task automatic chk(input string name, input batch_t act, input batch_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset;
      RST = 1'b1; STALL = 1'b0; DINEN = 1'b0;
      step();
      step();
      RST = 1'b0;
      mprimed = 1'b0; men = 1'b0; mdot = '0;
      for (int i = 0; i < E; i++) mfb[i] = '0;
   endtask

   // Reference: the E smallest of (input batch + retained batch) go out ascending, the rest are kept.
   task automatic model_step(input logic stall, input logic dinen, input batch_t din);
      rec_t all [2*E];
      rec_t t;
      if (stall) return;
      men = dinen && mprimed;
      if (!dinen) return;
      if (!mprimed) begin
         for (int i = 0; i < E; i++) mfb[i] = din[DATW*i +: DATW];
         mprimed = 1'b1;
         return;
      end
      for (int i = 0; i < E; i++) begin
         all[i]   = din[DATW*i +: DATW];
         all[E+i] = mfb[i];
      end
      for (int i = 1; i < 2*E; i++)
         for (int j = i; j > 0 && key_of(all[j]) < key_of(all[j-1]); j--) begin
            t = all[j]; all[j] = all[j-1]; all[j-1] = t;
         end
      for (int i = 0; i < E; i++) begin
         mdot[DATW*i +: DATW] = all[i];
         mfb[i] = all[E+i];
      end
   endtask

   initial begin
      vec_t tbl [10];
      logic [31:0] pl = 32'hFFFF_FFFF;
      int unsigned odd_base, even_base, k [E], t;
      logic [31:0] por, psum;
      logic sel;

      // Leaf checks
      cmp_a = 3; cmp_b = 4; #1; chk("cmp_3_4", cmp_rslt, 1);
      cmp_a = 4; cmp_b = 4; #1; chk("cmp_4_4", cmp_rslt, 0);
      cmp_a = 5; cmp_b = 4; #1; chk("cmp_5_4", cmp_rslt, 0);
      mux_in0 = mk(1, 2, 3, 4, 0); mux_in1 = mk(5, 6, 7, 8, 0);
      mux_sel = 1'b1; #1; chk("mux_sel1", mux_out, mk(1, 2, 3, 4, 0));
      mux_sel = 1'b0; #1; chk("mux_sel0", mux_out, mk(5, 6, 7, 8, 0));

      // Reset state
      do_reset();
      chk("rst_doten", DOTEN, 0);
      chk("rst_dot", DOT, 0);

      // Prime, merge, stall, idle, merge
      tbl[0] = '{0, 1, mk(1, 3, 5, 7, pl),     0, '0};
      tbl[1] = '{0, 1, mk(2, 4, 6, 8, pl),     1, mk(1, 2, 3, 4, pl)};
      tbl[2] = '{0, 1, mk(9, 11, 13, 15, pl),  1, mk(5, 6, 7, 8, pl)};
      tbl[3] = '{0, 1, mk(10, 12, 14, 16, pl), 1, mk(9, 10, 11, 12, pl)};
      tbl[4] = '{1, 1, mk(17, 19, 21, 23, pl), 1, mk(9, 10, 11, 12, pl)};
      tbl[5] = '{1, 1, mk(17, 19, 21, 23, pl), 1, mk(9, 10, 11, 12, pl)};
      tbl[6] = '{1, 1, mk(17, 19, 21, 23, pl), 1, mk(9, 10, 11, 12, pl)};
      tbl[7] = '{0, 0, mk(17, 19, 21, 23, pl), 0, mk(9, 10, 11, 12, pl)};
      tbl[8] = '{0, 1, mk(17, 18, 19, 20, pl), 1, mk(13, 14, 15, 16, pl)};
      tbl[9] = '{0, 1, mk(21, 22, 23, 24, pl), 1, mk(17, 18, 19, 20, pl)};
      for (int i = 0; i < 10; i++) begin
         STALL = tbl[i].stall; DINEN = tbl[i].dinen; DIN = tbl[i].din;
         step();
         chk($sformatf("tbl%0d_en", i), DOTEN, tbl[i].exp_en);
         chk($sformatf("tbl%0d_dot", i), DOT, tbl[i].exp_dot);
      end

      // Reset mid-stream drops the retained batch; the next batch primes again
      RST = 1'b1; STALL = 1'b0; DINEN = 1'b1; DIN = mk(1, 3, 5, 7, pl);
      step();
      RST = 1'b0;
      chk("midrst_dot", DOT, 0);
      step();
      chk("reprime_en", DOTEN, 0);
      DIN = mk(2, 4, 6, 8, pl);
      step();
      chk("reprime_dot", DOT, mk(1, 2, 3, 4, pl));

      // Ties: every key-5 record must come out once with its own payload
      do_reset();
      DINEN = 1'b1;
      DIN = {rec(9, 16), rec(9, 8), rec(5, 2), rec(5, 1)};
      step();
      DIN = {rec(9, 128), rec(9, 64), rec(6, 32), rec(5, 4)};
      step();
      chk("tie_keys", {DOT[195:192], DOT[131:128], DOT[67:64], DOT[3:0]}, 16'h6555);
      por = 0; psum = 0;
      for (int i = 0; i < 3; i++) begin
         por  = por | DOT[DATW*i+32 +: 32];
         psum = psum + DOT[DATW*i+32 +: 32];
      end
      chk("tie_payloads5", {por, psum}, {32'd7, 32'd7});
      chk("tie_rec6", DOT[DATW*3 +: DATW], rec(6, 32));
      DIN = mk(10, 10, 10, 10, 0);
      step();
      por = 0; psum = 0;
      for (int i = 0; i < E; i++) begin
         por  = por | DOT[DATW*i+32 +: 32];
         psum = psum + DOT[DATW*i+32 +: 32];
      end
      chk("tie_flush_keys", {DOT[195:192], DOT[131:128], DOT[67:64], DOT[3:0]}, 16'h9999);
      chk("tie_flush_payloads", {por, psum}, {32'd216, 32'd216});

      // System loop: comparator + mux choose between odd and even FIFO batches
      do_reset();
      odd_base = 1; even_base = 2;
      for (int s = 0; s < 10; s++) begin
         cmp_a = odd_base; cmp_b = even_base;
         mux_in0 = mk(odd_base, odd_base + 2, odd_base + 4, odd_base + 6, pl);
         mux_in1 = mk(even_base, even_base + 2, even_base + 4, even_base + 6, pl);
         #1;
         sel = cmp_rslt;
         chk($sformatf("sys%0d_sel", s), sel, (s % 2 == 0));
         mux_sel = sel;
         #1;
         DIN = mux_out; DINEN = 1'b1;
         step();
         if (sel) odd_base += 8; else even_base += 8;
         t = 4 * (s - 1) + 1;
         chk($sformatf("sys%0d_en", s), DOTEN, s != 0);
         if (s != 0) chk($sformatf("sys%0d_dot", s), DOT, mk(t, t + 1, t + 2, t + 3, pl));
      end

      // Randomized stream against the reference model
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 59) == 0) begin
            RST = 1'b1; DINEN = 1'b0; STALL = 1'b0;
            step();
            RST = 1'b0;
            mprimed = 1'b0; men = 1'b0; mdot = '0;
            for (int i = 0; i < E; i++) mfb[i] = '0;
         end else begin
            for (int i = 0; i < E; i++) k[i] = $urandom_range(0, 15);
            for (int i = 1; i < E; i++)
               for (int j = i; j > 0 && k[j] < k[j-1]; j--) begin
                  t = k[j]; k[j] = k[j-1]; k[j-1] = t;
               end
            for (int i = 0; i < E; i++) DIN[DATW*i +: DATW] = rec(k[i], ~k[i]);
            STALL = ($urandom_range(0, 4) == 0);
            DINEN = ($urandom_range(0, 3) != 0);
            step();
            model_step(STALL, DINEN, DIN);
         end
         chk("rnd_en", DOTEN, men);
         chk("rnd_dot", DOT, mdot);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
